// File: rtl/id_scoreboard_fwd.sv
// Decode-stage operand hazard and forwarding unit.
// A per-register pending scoreboard tracks outstanding writers, so that
// variable-latency units stall their dependants. Operands are bypassed from
// the completion bus and registered into the execute-stage pipeline register.
module id_scoreboard_fwd #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_SRC        = 3,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            d_valid_i,
   input  logic                            d_flush_i,
   input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] d_rs_addr_i,
   input  logic [NUM_SRC-1:0]              d_rs_use_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]   d_rs_data_i,
   input  logic [REG_ADDR_WIDTH-1:0]       d_rd_addr_i,
   input  logic                            d_rd_wr_i,
   input  logic                            c_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0]       c_addr_i,
   input  logic [DATA_WIDTH-1:0]           c_data_i,
   output logic                            stall_o,
   output logic                            e_valid_o,
   output logic [NUM_SRC*DATA_WIDTH-1:0]   e_rs_data_o,
   output logic [REG_ADDR_WIDTH-1:0]       e_rd_addr_o,
   output logic                            e_rd_wr_o,
   output logic [REG_ADDR_WIDTH:0]         busy_cnt_o,
   output logic [CNT_WIDTH-1:0]            stall_cnt_o,
   output logic                            sb_err_o
);

   localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
   localparam logic [REG_ADDR_WIDTH:0] BUSY_ONE  = 1;
   localparam logic [CNT_WIDTH-1:0]    STALL_ONE = 1;

   // One bit per architectural register: a writer is in flight.
   logic [NUM_REGS-1:0]               pending;

   logic [REG_ADDR_WIDTH-1:0]         rs_addr [NUM_SRC];
   logic [NUM_SRC-1:0]                src_bypass;
   logic [NUM_SRC-1:0]                raw_hazard;
   logic [NUM_SRC*DATA_WIDTH-1:0]     operand_flat;

   logic rd_nonzero;
   logic rd_bypass;
   logic waw_hazard;
   logic issue;
   logic set_pend;
   logic clr_pend;
   logic same_addr;
   logic clr_target_pending;
   logic busy_inc;
   logic busy_dec;
   logic err_hit;

   // Per-slot source decode: RAW detection and operand selection
   // (x0 reads as zero, a same-cycle completion beats the stale reg_file value).
   always_comb begin
      src_bypass   = '0;
      raw_hazard   = '0;
      operand_flat = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         rs_addr[j]    = d_rs_addr_i[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         src_bypass[j] = c_valid_i && (c_addr_i == rs_addr[j]) && (rs_addr[j] != '0);
         raw_hazard[j] = d_rs_use_i[j] && (rs_addr[j] != '0) &&
                         pending[rs_addr[j]] && !src_bypass[j];
         if (rs_addr[j] == '0) begin
            operand_flat[j*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else if (src_bypass[j]) begin
            operand_flat[j*DATA_WIDTH +: DATA_WIDTH] = c_data_i;
         end else begin
            operand_flat[j*DATA_WIDTH +: DATA_WIDTH] = d_rs_data_i[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Destination hazard, stall, issue and scoreboard set/clear decisions.
   always_comb begin
      rd_nonzero = (d_rd_addr_i != '0);
      rd_bypass  = c_valid_i && (c_addr_i == d_rd_addr_i) && rd_nonzero;
      waw_hazard = d_rd_wr_i && rd_nonzero && pending[d_rd_addr_i] && !rd_bypass;
      stall_o    = d_valid_i && ((|raw_hazard) || waw_hazard);
      issue      = d_valid_i && !stall_o && !d_flush_i;

      set_pend   = issue && d_rd_wr_i && rd_nonzero;
      clr_pend   = c_valid_i && (c_addr_i != '0);
      same_addr  = set_pend && (c_addr_i == d_rd_addr_i);

      clr_target_pending = pending[c_addr_i];
      busy_inc   = set_pend && !pending[d_rd_addr_i];
      busy_dec   = clr_pend && clr_target_pending && !same_addr;
      err_hit    = clr_pend && !clr_target_pending && !same_addr;
   end

   // Execute-stage pipeline register; data fields hold across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_o   <= 1'b0;
         e_rs_data_o <= '0;
         e_rd_addr_o <= '0;
         e_rd_wr_o   <= 1'b0;
      end else if (issue) begin
         e_valid_o   <= 1'b1;
         e_rs_data_o <= operand_flat;
         e_rd_addr_o <= d_rd_addr_i;
         e_rd_wr_o   <= d_rd_wr_i;
      end else begin
         e_valid_o   <= 1'b0;
         e_rd_wr_o   <= 1'b0;
      end
   end

   // Pending scoreboard: a set in the same cycle as a clear to the same register wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         if (clr_pend) begin
            pending[c_addr_i] <= 1'b0;
         end
         if (set_pend) begin
            pending[d_rd_addr_i] <= 1'b1;
         end
      end
   end

   // Incremental count of pending registers, kept equal to popcount(pending).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt_o <= '0;
      end else begin
         case ({busy_inc, busy_dec})
            2'b10:   busy_cnt_o <= busy_cnt_o + BUSY_ONE;
            2'b01:   busy_cnt_o <= busy_cnt_o - BUSY_ONE;
            default: busy_cnt_o <= busy_cnt_o;
         endcase
      end
   end

   // Sticky flag for a completion that targets a register with no writer outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_err_o <= 1'b0;
      end else if (err_hit) begin
         sb_err_o <= 1'b1;
      end
   end

   // Saturating stall-cycle performance counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
      end else if (stall_o && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + STALL_ONE;
      end
   end

endmodule

// File: tb/tb_id_scoreboard_fwd.sv
// Self-checking bench for id_scoreboard_fwd: directed hazard/bypass scenarios
// followed by a short random burst, all checked against a reference model and
// an expected-issue queue.
module tb_id_scoreboard_fwd;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NS = 3;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              d_valid_i = 1'b0;
   logic              d_flush_i = 1'b0;
   logic [NS*AW-1:0]  d_rs_addr_i = '0;
   logic [NS-1:0]     d_rs_use_i = '0;
   logic [NS*DW-1:0]  d_rs_data_i = '0;
   logic [AW-1:0]     d_rd_addr_i = '0;
   logic              d_rd_wr_i = 1'b0;
   logic              c_valid_i = 1'b0;
   logic [AW-1:0]     c_addr_i = '0;
   logic [DW-1:0]     c_data_i = '0;
   logic              stall_o;
   logic              e_valid_o;
   logic [NS*DW-1:0]  e_rs_data_o;
   logic [AW-1:0]     e_rd_addr_o;
   logic              e_rd_wr_o;
   logic [AW:0]       busy_cnt_o;
   logic [CW-1:0]     stall_cnt_o;
   logic              sb_err_o;

   typedef struct {
      logic [NS*DW-1:0] data;
      logic [AW-1:0]    rd;
      logic             wr;
   } exp_t;

   exp_t exp_q[$];

   bit   m_pending [32];
   bit   m_err;
   int   m_stall;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   id_scoreboard_fwd #(
      .DATA_WIDTH(DW),
      .REG_ADDR_WIDTH(AW),
      .NUM_SRC(NS),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .d_valid_i(d_valid_i),
      .d_flush_i(d_flush_i),
      .d_rs_addr_i(d_rs_addr_i),
      .d_rs_use_i(d_rs_use_i),
      .d_rs_data_i(d_rs_data_i),
      .d_rd_addr_i(d_rd_addr_i),
      .d_rd_wr_i(d_rd_wr_i),
      .c_valid_i(c_valid_i),
      .c_addr_i(c_addr_i),
      .c_data_i(c_data_i),
      .stall_o(stall_o),
      .e_valid_o(e_valid_o),
      .e_rs_data_o(e_rs_data_o),
      .e_rd_addr_o(e_rd_addr_o),
      .e_rd_wr_o(e_rd_wr_o),
      .busy_cnt_o(busy_cnt_o),
      .stall_cnt_o(stall_cnt_o),
      .sb_err_o(sb_err_o)
   );

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cbyp(input logic [AW-1:0] a);
      return c_valid_i && (c_addr_i == a) && (a != '0);
   endfunction

   function automatic int modelBusy();
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(m_pending[r]);
      return n;
   endfunction

   task automatic modelClear();
      for (int r = 0; r < 32; r++) m_pending[r] = 1'b0;
      m_err   = 1'b0;
      m_stall = 0;
      exp_q.delete();
   endtask

   task automatic verifyRegs(input bit exp_valid);
      exp_t e;
      checkOutput("e_valid", e_valid_o, exp_valid);
      if (exp_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("e_rs_data", e_rs_data_o, e.data);
         checkOutput("e_rd_addr", e_rd_addr_o, e.rd);
         checkOutput("e_rd_wr", e_rd_wr_o, e.wr);
      end else begin
         checkOutput("e_rd_wr_bubble", e_rd_wr_o, 1'b0);
      end
      checkOutput("busy_cnt", busy_cnt_o, modelBusy());
      checkOutput("sb_err", sb_err_o, m_err);
      checkOutput("stall_cnt", stall_cnt_o, m_stall);
   endtask

   // Drives one decode/completion cycle at posedge+1, checks the combinational
   // stall, lets the edge pass, then checks the registered outputs.
   task automatic applyStimulus(
      input logic v, input logic fl,
      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
      input logic [NS-1:0] use_bits,
      input logic [DW-1:0] r0, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
      input logic [AW-1:0] rd, input logic wr,
      input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      logic [AW-1:0] a [NS];
      logic [DW-1:0] r [NS];
      bit   raw, waw, exp_stall, issue, set_p, clr_p, same;
      exp_t e;
      a[0] = a0; a[1] = a1; a[2] = a2;
      r[0] = r0; r[1] = r1; r[2] = r2;
      d_valid_i   = v;
      d_flush_i   = fl;
      d_rs_addr_i = {a2, a1, a0};
      d_rs_use_i  = use_bits;
      d_rs_data_i = {r2, r1, r0};
      d_rd_addr_i = rd;
      d_rd_wr_i   = wr;
      c_valid_i   = cv;
      c_addr_i    = ca;
      c_data_i    = cd;
      #1;
      raw = 1'b0;
      for (int j = 0; j < NS; j++) begin
         if (use_bits[j] && a[j] != '0 && m_pending[a[j]] && !cbyp(a[j])) raw = 1'b1;
      end
      waw = wr && rd != '0 && m_pending[rd] && !cbyp(rd);
      exp_stall = v && (raw || waw);
      checkOutput("stall", stall_o, exp_stall);
      issue = v && !exp_stall && !fl;
      if (issue) begin
         e.data = '0;
         for (int j = 0; j < NS; j++) begin
            if (a[j] == '0)     e.data[j*DW +: DW] = '0;
            else if (cbyp(a[j])) e.data[j*DW +: DW] = cd;
            else                e.data[j*DW +: DW] = r[j];
         end
         e.rd = rd;
         e.wr = wr;
         exp_q.push_back(e);
      end
      set_p = issue && wr && rd != '0;
      clr_p = cv && ca != '0;
      same  = set_p && (rd == ca);
      @(posedge clk);
      if (clr_p && !same) begin
         if (m_pending[ca]) m_pending[ca] = 1'b0;
         else               m_err = 1'b1;
      end
      if (set_p) m_pending[rd] = 1'b1;
      if (exp_stall && m_stall != (2**CW - 1)) m_stall++;
      #1;
      verifyRegs(issue);
   endtask

   initial begin
      $display("[TB] start");
      modelClear();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_e_valid", e_valid_o, 1'b0);
      checkOutput("rst_e_data", e_rs_data_o, '0);
      checkOutput("rst_e_rd", e_rd_addr_o, '0);
      checkOutput("rst_busy", busy_cnt_o, '0);
      checkOutput("rst_stall_cnt", stall_cnt_o, '0);
      checkOutput("rst_err", sb_err_o, 1'b0);
      checkOutput("rst_stall", stall_o, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Divide writing x5 issues, dependant stalls until completion bypass.
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 5, 1, 0, 0, 0);
      checkOutput("div_busy", busy_cnt_o, 1);
      repeat (3) applyStimulus(1, 0, 5, 0, 0, 3'b001, 32'hDEAD, 0, 0, 6, 0, 0, 0, 0);
      applyStimulus(1, 0, 5, 0, 0, 3'b001, 32'hDEAD, 0, 0, 6, 0, 1, 5, 32'h7);
      checkOutput("div_slot0", e_rs_data_o[DW-1:0], 32'h7);
      checkOutput("div_busy_after", busy_cnt_o, 0);

      // x0 source reads zero; completion to x0 is ignored.
      applyStimulus(1, 0, 0, 7, 0, 3'b011, 32'hFFFF_FFFF, 32'hAAAA, 0, 0, 1, 1, 0, 32'h1234);
      checkOutput("x0_slot0", e_rs_data_o[DW-1:0], 32'h0);
      checkOutput("x0_err", sb_err_o, 1'b0);

      // Same-cycle completion and new writer on x3: set wins.
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3, 1, 1, 3, 32'h33);
      checkOutput("same_busy", busy_cnt_o, 1);
      checkOutput("same_err", sb_err_o, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 3, 32'h33);

      // WAW on x8 stalls until x8 completes.
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 8, 1, 0, 0, 0);
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 8, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 8, 1, 1, 8, 32'h88);
      checkOutput("waw_busy", busy_cnt_o, 1);
      applyStimulus(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 8, 32'h88);

      // Flush with a hazard present, then flush of a writer: nothing issues.
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 10, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 10, 0, 3'b010, 0, 32'h5, 0, 12, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 11, 1, 0, 0, 0);
      checkOutput("flush_busy", busy_cnt_o, 1);

      // Completion to a non-pending register raises the sticky error.
      applyStimulus(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 9, 32'h9);
      applyStimulus(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("err_held", sb_err_o, 1'b1);

      // Long stall on x10 drives the narrow counter into saturation.
      repeat (16) applyStimulus(1, 0, 0, 0, 10, 3'b100, 0, 0, 32'h1, 13, 1, 0, 0, 0);
      checkOutput("stall_sat", stall_cnt_o, 4'hF);

      // Reset while stalling clears everything, late completion is flagged.
      checkOutput("pre_rst_stall", stall_o, 1'b1);
      rst_n = 1'b0;
      #1;
      modelClear();
      checkOutput("midrst_stall", stall_o, 1'b0);
      checkOutput("midrst_busy", busy_cnt_o, '0);
      checkOutput("midrst_err", sb_err_o, 1'b0);
      checkOutput("midrst_stall_cnt", stall_cnt_o, '0);
      checkOutput("midrst_e_data", e_rs_data_o, '0);
      checkOutput("midrst_e_rd", e_rd_addr_o, '0);
      checkOutput("midrst_e_valid", e_valid_o, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 10, 32'hA);
      checkOutput("late_err", sb_err_o, 1'b1);

      // Random burst over a small register window to mix hazards and bypasses.
      for (int i = 0; i < 60; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                       AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                       NS'($urandom_range(0, 7)),
                       $urandom, $urandom, $urandom,
                       AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 2) == 0, AW'($urandom_range(0, 3)), $urandom);
      end

      checkOutput("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
